// File: rtl/symbol_stream_arbiter.sv
// Round-robin sharing of one 2-bit-symbol pattern detector among NCH streams.
// Each channel's detector state is saved/restored per burst; hits are counted per channel.
module symbol_stream_arbiter #(
  parameter int NCH       = 4,
  parameter int CH_W      = 2,
  parameter int CNT_W     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       req,
  input  logic [2*NCH-1:0]     sym_in,
  input  logic [NCH-1:0]       last,
  output logic [NCH-1:0]       gnt,
  output logic                 hit,
  output logic [CH_W-1:0]      hit_ch,
  input  logic [CH_W-1:0]      cnt_sel,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic                 busy
);

  localparam int BW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST);

  localparam logic [1:0] DET_S0 = 2'd0;
  localparam logic [1:0] DET_S1 = 2'd1;
  localparam logic [1:0] DET_S2 = 2'd2;
  localparam logic [1:0] DET_S3 = 2'd3;

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} arb_state_e;

  // Handshake: a symbol of channel i is accepted in any cycle where gnt[i] and
  // req[i] are both high; sym/last are only sampled on accept, req may drop anytime.

  arb_state_e           state_q, state_d;
  logic [NCH-1:0]       gnt_q, gnt_d;
  logic [CH_W-1:0]      cur_q, cur_d;
  logic [CH_W-1:0]      ptr_q, ptr_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [1:0]           det_q [NCH];
  logic [CNT_W-1:0]     cnt_q [NCH];
  logic                 hit_q, hit_d;
  logic [CH_W-1:0]      hit_ch_q, hit_ch_d;

  logic [1:0]           sym_a [NCH];
  logic [1:0]           cur_sym;
  logic                 cur_req;
  logic                 cur_last;
  logic                 accept;
  logic                 burst_end;
  logic [1:0]           det_nxt;
  logic                 pick_found;
  logic [CH_W-1:0]      pick_ch;
  logic [CH_W-1:0]      idx;

  function automatic logic [1:0] det_next(input logic [1:0] s, input logic [1:0] sym);
    logic [1:0] n;
    case (sym)
      2'd0:    n = s;
      2'd1:    n = DET_S1;
      2'd2:    n = (s == DET_S1 || s == DET_S2) ? DET_S2 : DET_S0;
      default: n = (s == DET_S2 || s == DET_S3) ? DET_S3 : DET_S0;
    endcase
    return n;
  endfunction

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      sym_a[i] = sym_in[2*i +: 2];
    end
    cur_sym   = sym_a[cur_q];
    cur_req   = req[cur_q];
    cur_last  = last[cur_q];
    accept    = (state_q == ST_GRANT) && cur_req;
    det_nxt   = det_next(det_q[cur_q], cur_sym);
    // A dropped request ends the burst as well as last / the final allowed beat.
    burst_end = (state_q == ST_GRANT) &&
                (!cur_req || cur_last || (beat_q == BW'(MAX_BURST - 1)));
    hit_d     = accept && (det_nxt == DET_S3);
    hit_ch_d  = hit_d ? cur_q : '0;
  end

  // Round-robin pick: iterate from farthest to nearest so the nearest requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    idx        = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = CH_W'((int'(ptr_q) + k) % NCH);
      if (req[idx]) begin
        pick_found = 1'b1;
        pick_ch    = idx;
      end
    end
  end

  // Arbiter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      cur_q   <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

  // Arbiter next-state logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d        = ST_GRANT;
          gnt_d          = '0;
          gnt_d[pick_ch] = 1'b1;
          cur_d          = pick_ch;
          beat_d         = '0;
        end
      end
      ST_GRANT: begin
        if (accept) beat_d = beat_q + 1'b1;
        if (burst_end) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = (cur_q == CH_W'(NCH - 1)) ? '0 : cur_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy    = (state_q == ST_GRANT);
    gnt     = gnt_q;
    hit     = hit_q;
    hit_ch  = hit_ch_q;
    hit_cnt = (int'(cnt_sel) < NCH) ? cnt_q[cnt_sel] : '0;
  end

  // Per-channel detector context, hit counters and hit pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        det_q[i] <= DET_S0;
        cnt_q[i] <= '0;
      end
      hit_q    <= 1'b0;
      hit_ch_q <= '0;
    end else begin
      if (accept) det_q[cur_q] <= det_nxt;
      if (hit_d && (cnt_q[cur_q] != {CNT_W{1'b1}})) cnt_q[cur_q] <= cnt_q[cur_q] + 1'b1;
      hit_q    <= hit_d;
      hit_ch_q <= hit_ch_d;
    end
  end

endmodule

// File: tb/tb_symbol_stream_arbiter.sv
// Bench for symbol_stream_arbiter: queue-driven and random stimulus compared
// cycle by cycle against a transaction-level reference model.
module tb_symbol_stream_arbiter;

  localparam int NCH       = 4;
  localparam int CH_W      = 2;
  localparam int CNT_W     = 8;
  localparam int MAX_BURST = 16;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NCH-1:0]       req = '0;
  logic [2*NCH-1:0]     sym_in = '0;
  logic [NCH-1:0]       last = '0;
  logic [CH_W-1:0]      cnt_sel = '0;
  logic [NCH-1:0]       gnt;
  logic                 hit;
  logic [CH_W-1:0]      hit_ch;
  logic [CNT_W-1:0]     hit_cnt;
  logic                 busy;

  symbol_stream_arbiter #(
    .NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .sym_in(sym_in), .last(last),
    .gnt(gnt), .hit(hit), .hit_ch(hit_ch), .cnt_sel(cnt_sel),
    .hit_cnt(hit_cnt), .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Detector transitions straight from the symbol table: det_tbl[state][symbol].
  int det_tbl [4][4] = '{'{0, 1, 0, 0}, '{1, 1, 2, 0}, '{2, 1, 2, 3}, '{3, 1, 0, 3}};
  int m_owner;
  int m_ptr;
  int m_beats;
  int m_det [NCH];
  int m_cnt [NCH];
  bit m_hit;
  logic [CH_W-1:0] exp_q [$];

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_beats = 0;
    m_hit   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_det[i] = 0;
      m_cnt[i] = 0;
    end
    exp_q.delete();
  endtask

  function automatic int model_step();
    int acc;
    bit done;
    acc   = -1;
    done  = 1'b0;
    m_hit = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < NCH; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % NCH]) begin
          m_owner = (m_ptr + k) % NCH;
          m_beats = 0;
        end
      end
    end else begin
      if (req[m_owner]) begin
        acc = m_owner;
        m_det[acc] = det_tbl[m_det[acc]][sym_in[2*acc +: 2]];
        m_beats++;
        if (m_det[acc] == 3) begin
          m_hit = 1'b1;
          exp_q.push_back(CH_W'(acc));
          if (m_cnt[acc] < CNT_MAX) m_cnt[acc]++;
        end
        done = last[acc] || (m_beats == MAX_BURST);
      end else begin
        done = 1'b1;
      end
      if (done) begin
        m_ptr   = (m_owner + 1) % NCH;
        m_owner = -1;
      end
    end
    return acc;
  endfunction

  // ---------------- driver state and monitor ----------------
  logic [2:0] tx_q [NCH][$];   // {last, sym} per channel
  bit rand_mode = 1'b0;
  int hits_seen;
  int last_hit_ch;
  int grant_log [$];
  int burst_len [$];
  logic [NCH-1:0] prev_gnt;

  task automatic push(input int ch, input int sym, input bit lst);
    tx_q[ch].push_back({lst, 2'(sym)});
  endtask

  function automatic bit pending();
    bit p;
    p = (m_owner >= 0);
    for (int i = 0; i < NCH; i++) if (tx_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic check_outputs();
    logic [CH_W-1:0] e;
    check_eq("gnt", 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check_eq("busy", 32'(busy), 32'(m_owner >= 0));
    check_eq("hit", 32'(hit), 32'(m_hit));
    if (m_hit && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("hit_ch", 32'(hit_ch), 32'(e));
    end
    check_eq("hit_cnt", 32'(hit_cnt), 32'(m_cnt[cnt_sel]));
    if (hit) begin
      hits_seen++;
      last_hit_ch = int'(hit_ch);
    end
    if (gnt != '0 && prev_gnt == '0) begin
      for (int i = 0; i < NCH; i++) if (gnt[i]) grant_log.push_back(i);
      burst_len.push_back(0);
    end
    prev_gnt = gnt;
  endtask

  task automatic cycle();
    int acc;
    logic [NCH-1:0] g_before;
    g_before = gnt;
    if (rand_mode) begin
      req    = NCH'($urandom);
      sym_in = (2*NCH)'($urandom);
      last   = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (tx_q[i].size() > 0) begin
          {last[i], sym_in[2*i +: 2]} = tx_q[i][0];
          req[i] = 1'b1;
        end else begin
          last[i] = 1'b0;
          sym_in[2*i +: 2] = 2'd0;
          req[i] = 1'b0;
        end
      end
    end
    cnt_sel = CH_W'($urandom_range(0, NCH - 1));
    acc = model_step();
    if (acc >= 0 && !rand_mode && tx_q[acc].size() > 0) void'(tx_q[acc].pop_front());
    @(negedge clk);
    if ((g_before & req) != '0 && burst_len.size() > 0) burst_len[burst_len.size() - 1]++;
    check_outputs();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    check_eq({"drain_", tag}, 32'(pending()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = '0;
    sym_in  = '0;
    last    = '0;
    cnt_sel = '0;
    rand_mode = 1'b0;
    for (int i = 0; i < NCH; i++) tx_q[i].delete();
    model_reset();
    hits_seen   = 0;
    last_hit_ch = -1;
    grant_log.delete();
    burst_len.delete();
    prev_gnt = '0;
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_hit", 32'(hit), 32'd0);
    check_eq("rst_hit_ch", 32'(hit_ch), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    @(negedge clk);

    // ch0 streams 1,2,3,3(last): two hits, counter 2
    do_reset();
    push(0, 1, 0); push(0, 2, 0); push(0, 3, 0); push(0, 3, 1);
    drain("t1", 50);
    run_cycles(2);
    check_eq("t1_hits", 32'(hits_seen), 32'd2);
    check_eq("t1_hit_ch", 32'(last_hit_ch), 32'd0);
    cnt_sel = 2'd0; #1;
    check_eq("t1_cnt0", 32'(hit_cnt), 32'd2);
    check_eq("t1_gnt_idle", 32'(gnt), 32'd0);

    // saved context across interleaved bursts
    do_reset();
    push(1, 1, 0); push(1, 2, 1); push(2, 1, 1); push(1, 3, 1);
    drain("t2", 50);
    check_eq("t2_hits", 32'(hits_seen), 32'd1);
    check_eq("t2_hit_ch", 32'(last_hit_ch), 32'd1);
    check_eq("t2_ngrants", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() == 3) begin
      check_eq("t2_order0", 32'(grant_log[0]), 32'd1);
      check_eq("t2_order1", 32'(grant_log[1]), 32'd2);
      check_eq("t2_order2", 32'(grant_log[2]), 32'd1);
    end
    cnt_sel = 2'd2; #1;
    check_eq("t2_cnt2", 32'(hit_cnt), 32'd0);

    // all requesting, single-symbol bursts: strict rotation
    do_reset();
    for (int r = 0; r < 2; r++) for (int c = 0; c < NCH; c++) push(c, 0, 1);
    drain("t3", 100);
    check_eq("t3_ngrants", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check_eq("t3_order", 32'(grant_log[i]), 32'(i % NCH));

    // MAX_BURST forced release, then pending ch0 before ch3 again
    do_reset();
    for (int i = 0; i < MAX_BURST + 4; i++) push(3, 0, 0);
    run_cycles(2);
    push(0, 0, 1);
    drain("t4", 200);
    check_eq("t4_ngrants", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() == 3 && burst_len.size() == 3) begin
      check_eq("t4_g0", 32'(grant_log[0]), 32'd3);
      check_eq("t4_g1", 32'(grant_log[1]), 32'd0);
      check_eq("t4_g2", 32'(grant_log[2]), 32'd3);
      check_eq("t4_len0", 32'(burst_len[0]), 32'(MAX_BURST));
      check_eq("t4_len1", 32'(burst_len[1]), 32'd1);
      check_eq("t4_len2", 32'(burst_len[2]), 32'd4);
    end

    // counter saturation, then 2 from MATCH and a non-hitting 3
    do_reset();
    push(0, 1, 0); push(0, 2, 0);
    for (int i = 0; i < 300; i++) push(0, 3, 0);
    push(0, 2, 0); push(0, 3, 1);
    drain("t5", 1000);
    check_eq("t5_hits", 32'(hits_seen), 32'd300);
    cnt_sel = 2'd0; #1;
    check_eq("t5_cnt_sat", 32'(hit_cnt), 32'(CNT_MAX));

    // reset in the middle of a burst wipes ch0 context
    do_reset();
    push(0, 1, 0); push(0, 2, 0); push(0, 0, 0);
    n = 0;
    while (tx_q[0].size() > 1 && n < 20) begin
      cycle();
      n++;
    end
    check_eq("t6_mid_burst", 32'(busy), 32'd1);
    do_reset();
    push(0, 3, 1);
    drain("t6", 20);
    check_eq("t6_hits", 32'(hits_seen), 32'd0);

    // random queued bursts
    do_reset();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 40; i++)
        push(c, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    drain("rand_q", 2000);

    // fully random per-cycle req/sym/last
    rand_mode = 1'b1;
    run_cycles(600);
    rand_mode = 1'b0;
    drain("rand_free", 100);
    for (int c = 0; c < NCH; c++) begin
      cnt_sel = CH_W'(c); #1;
      check_eq("final_cnt", 32'(hit_cnt), 32'(m_cnt[c]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/symbol_stream_arbiter.md
Name: symbol_stream_arbiter

Overview:
- Shares one 2-bit-symbol pattern detector among NCH requesters, each streaming its own symbols.
- Round-robin arbitration grants one requester per burst.
- A per-channel detector state is saved and restored on each context switch, so interleaved streams are detected independently.
- Reports a hit pulse with channel id and keeps a saturating per-channel hit counter readable through a select port.

Parameters:
- NCH, 4, number of requesters (2..8).
- CH_W, 2, channel id width; must satisfy 2^CH_W >= NCH.
- CNT_W, 8, width of each per-channel hit counter.
- MAX_BURST, 16, maximum symbols accepted per grant before forced release (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NCH  per-channel request; held while the channel has symbols.
- sym_in  in  2*NCH  per-channel symbol; channel i uses bits [2i+1:2i].
- last  in  NCH  per-channel end-of-burst flag, qualified with the accepted symbol.
- gnt  out  NCH  one-hot grant, registered.
- hit  out  1  one-cycle pulse: the detector entered or stayed in MATCH.
- hit_ch  out  CH_W  channel that produced hit; valid only while hit=1.
- cnt_sel  in  CH_W  selects the counter shown on hit_cnt.
- hit_cnt  out  CNT_W  combinational read of the selected channel's counter.
- busy  out  1  high while in GRANT state.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - gnt=0, hit=0, hit_ch=0, busy=0.
  - All counters and saved detector states are 0 (state S0).
  - Round-robin pointer is 0, FSM goes to IDLE.
  - Reset mid-burst aborts the burst with no hit.
- Detector states: S0, S1, S2, S3 (S3 = MATCH). Next state for each accepted symbol:
  - sym 0: hold the current state.
  - sym 1: go to S1 from any state.
  - sym 2: S0->S0, S1->S2, S2->S2, S3->S0.
  - sym 3: S0->S0, S1->S0, S2->S3, S3->S3.
- Accept: a cycle with gnt[i]=1 and req[i]=1. That cycle's sym_in of channel i goes through the detector using the saved state of channel i, and the result is written back at the clock edge.
- Hit:
  - When an accepted symbol's next state is S3, the next cycle has hit=1 and hit_ch=i (1-cycle latency).
  - On the same edge, counter i increments and saturates at 2^CNT_W-1.
  - Consecutive 3s in S3 produce a hit on every accepted symbol.
- Arbiter FSM, states IDLE and GRANT:
  - IDLE: if any req is high, pick the first requesting channel at or after the pointer, wrapping modulo NCH. Register gnt to it and go to GRANT. If no req is high, stay in IDLE.
  - GRANT: the burst ends on any of these:
    - an accept with last[i]=1;
    - an accept that is the MAX_BURST-th of the burst;
    - req[i]=0 in a grant cycle, with no accept that cycle.
  - On burst end: gnt is cleared on the next edge, the FSM returns to IDLE, and the pointer becomes i+1 mod NCH.
  - There is always at least one idle cycle between grants, so one channel can have at most one grant per two cycles.
- Burst length: counter reset on each grant. Symbols of non-granted channels are ignored and their saved states are untouched.
- sym/last of a non-accepted cycle have no effect.
- req of a channel may drop at any time. Its saved detector state persists across bursts; only reset clears it.
- hit_cnt is combinational from cnt_sel. For cnt_sel>=NCH, hit_cnt is 0.

Test Plan:
- Reset, then ch0 streams 1,2,3,3 with last on the 4th symbol -> hits in cycles 3 and 4 after grant, hit_ch=0, hit_cnt(sel 0)=2, gnt returns to 0.
- ch1 sends 1,2 (last), ch2 sends 1 (last), ch1 sends 3 (last) -> exactly one hit, hit_ch=1, on ch1's second burst; ch2 counter=0. This confirms saved state across context switches.
- req=4'b1111 held continuously, each channel sending single-symbol bursts (last=1) -> gnt order 0,1,2,3,0, each grant separated by one IDLE cycle.
- MAX_BURST=16 with ch3 holding req and never asserting last -> exactly 16 accepts, then gnt drops. A pending ch0 request is granted next, and ch3 is regranted only after ch0.
- Counter saturation at CNT_W=8: 300 hits on ch0 -> hit_cnt=255. Sending sym 2 from S3 returns to S0, and the following sym 3 gives no hit.
- Assert rst_n=0 for one cycle mid-burst after 1,2 on ch0 -> gnt and busy clear immediately. A later 3 on ch0 gives no hit because its state was reset to S0.
